// File: rtl/truth_table_checker.sv
// ============================================================================
// Module   : truth_table_checker
// Purpose  : Walks the four 2-input vectors through two gate implementations
//            and counts per-implementation mismatches against a truth table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_checker #(
  parameter int         SETTLE = 1,
  parameter logic [3:0] EXPECT = 4'b1110
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       a,
  input  logic       b,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_a,
  output logic [2:0] err_b,
  output logic       fail_valid,
  output logic [1:0] fail_idx
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] C_SETTLE = 4'(SETTLE);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] err_a_q, err_a_d;
  logic [2:0] err_b_q, err_b_d;
  logic       fail_valid_q, fail_valid_d;
  logic [1:0] fail_idx_q, fail_idx_d;
  logic       mis_a, mis_b;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= 4'd0;
      err_a_q      <= 3'd0;
      err_b_q      <= 3'd0;
      fail_valid_q <= 1'b0;
      fail_idx_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      err_a_q      <= err_a_d;
      err_b_q      <= err_b_d;
      fail_valid_q <= fail_valid_d;
      fail_idx_q   <= fail_idx_d;
    end
  end

  assign mis_a = (a != EXPECT[idx_q]);
  assign mis_b = (b != EXPECT[idx_q]);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    err_a_d      = err_a_q;
    err_b_d      = err_b_q;
    fail_valid_d = fail_valid_q;
    fail_idx_d   = fail_idx_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = HOLD;
          idx_d        = 2'd0;
          cnt_d        = C_SETTLE;
          err_a_d      = 3'd0;
          err_b_d      = 3'd0;
          fail_valid_d = 1'b0;
          fail_idx_d   = 2'd0;
        end
      end
      HOLD: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = SAMPLE;
      end
      SAMPLE: begin
        // At most four increments per run, so 3 bits never wrap.
        if (mis_a) err_a_d = err_a_q + 3'd1;
        if (mis_b) err_b_d = err_b_q + 3'd1;
        if ((mis_a || mis_b) && !fail_valid_q) begin
          fail_valid_d = 1'b1;
          fail_idx_d   = idx_q;
        end
        if (idx_q == 2'd3) begin
          state_d = DONE;
        end else begin
          state_d = HOLD;
          idx_d   = idx_q + 2'd1;
          cnt_d   = C_SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == HOLD) || (state_q == SAMPLE);
    done = (state_q == DONE);
    x    = busy & idx_q[1];
    y    = busy & idx_q[0];
    pass = done && (err_a_q == 3'd0) && (err_b_q == 3'd0);
  end

  assign err_a      = err_a_q;
  assign err_b      = err_b_q;
  assign fail_valid = fail_valid_q;
  assign fail_idx   = fail_idx_q;

endmodule

`default_nettype wire
